// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; all zeros when disabled.
module dec3to8
    import rr_arbiter8_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [NREQ-1:0]  dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a bounded hold time and a
// mandatory idle turnaround cycle between consecutive grants.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam bit                LIMIT_EN  = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
    logic [IDX_W-1:0]  gntIdx_q, gntIdx_d;
    logic              gntValid_q, gntValid_d;
    logic              timeout_q, timeout_d;
    logic [IDX_W:0]    pick;

    // Returns {found, index} of the first set request searching upward from p.
    function automatic logic [IDX_W:0] rrPick(input logic [NREQ-1:0]  r,
                                              input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] cand;
        rrPick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = p + IDX_W'(i);
            if (r[cand]) begin
                rrPick = {1'b1, cand};
            end
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        holdCnt_d  = holdCnt_q;
        gntIdx_d   = gntIdx_q;
        gntValid_d = gntValid_q;
        timeout_d  = 1'b0;
        pick       = rrPick(req, ptr_q);

        case (state_q)
            IDLE: begin
                gntValid_d = 1'b0;
                if (pick[IDX_W]) begin
                    state_d    = GRANT;
                    gntIdx_d   = pick[IDX_W-1:0];
                    gntValid_d = 1'b1;
                    holdCnt_d  = '0;
                end
            end
            GRANT: begin
                // A voluntary release wins over the limit, so no timeout pulse then.
                if (!req[gntIdx_q] || (LIMIT_EN && holdCnt_q == HOLD_LAST)) begin
                    state_d    = IDLE;
                    gntValid_d = 1'b0;
                    ptr_d      = gntIdx_q + 1'b1;
                    timeout_d  = req[gntIdx_q];
                end else if (holdCnt_q != '1) begin
                    holdCnt_d = holdCnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                gntValid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            holdCnt_q  <= '0;
            gntIdx_q   <= '0;
            gntValid_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            holdCnt_q  <= holdCnt_d;
            gntIdx_q   <= gntIdx_d;
            gntValid_q <= gntValid_d;
            timeout_q  <= timeout_d;
        end
    end

    dec3to8 u_dec (
        .idx_i (gntIdx_q),
        .en_i  (gntValid_q),
        .dec_o (gnt)
    );

    assign gnt_idx   = gntIdx_q;
    assign gnt_valid = gntValid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Table-driven, scoreboarded bench for rr_arbiter8 built with MAX_HOLD=4.
module tb_rr_arbiter8;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int   testsRun;
    int   testsFailed;
    int   vecId;
    exp_t scoreboard[$];
    vec_t vecs[37];

    rr_arbiter8 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // Free-running 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compareField(input int id, input string name,
                                input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL vec%0d %s: got %h, expected %h", id, name, actual, expected);
        end
    endtask

    // Pops the oldest expectation and compares it with what the DUT shows now
    task automatic checkOutput();
        exp_t e;
        if (scoreboard.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = scoreboard.pop_front();
            compareField(e.id, "gnt",       gnt,              e.gnt);
            compareField(e.id, "gnt_idx",   {5'd0, gnt_idx},  {5'd0, e.idx});
            compareField(e.id, "gnt_valid", {7'd0, gnt_valid},{7'd0, e.valid});
            compareField(e.id, "timeout",   {7'd0, timeout},  {7'd0, e.to});
        end
    endtask

    // Drives one cycle of inputs, queues its expectation, and checks after the edge
    task automatic applyStimulus(input logic r, input logic [7:0] rq,
                                 input logic [7:0] eg, input logic [2:0] ei,
                                 input logic ev, input logic et);
        exp_t e;
        rst    = r;
        req    = rq;
        e.id    = vecId;
        e.gnt   = eg;
        e.idx   = ei;
        e.valid = ev;
        e.to    = et;
        scoreboard.push_back(e);
        vecId++;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        vecId       = 0;
        rst         = 1'b1;
        req         = 8'h00;

        // Reset with all requests high, then first grant goes to 0
        vecs[0]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        // Requesters 2 and 7, each releasing after three granted cycles
        vecs[4]  = '{1'b0, 8'h84, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h84, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h84, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h80, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0};
        // Park pointer at 7, then check wrap to 0
        vecs[14] = '{1'b0, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 8'h00, 3'd6, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 8'h01, 8'h00, 3'd7, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        // Timeouts with requests 0 and 1 held constantly
        vecs[20] = '{1'b1, 8'h03, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[24] = '{1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[25] = '{1'b0, 8'h03, 8'h00, 3'd0, 1'b0, 1'b1};
        vecs[26] = '{1'b0, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[27] = '{1'b0, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[28] = '{1'b0, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[29] = '{1'b0, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[30] = '{1'b0, 8'h03, 8'h00, 3'd1, 1'b0, 1'b1};
        vecs[31] = '{1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[32] = '{1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[33] = '{1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[34] = '{1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
        // Release coinciding with the hold limit: no timeout pulse
        vecs[35] = '{1'b0, 8'h02, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[36] = '{1'b0, 8'h02, 8'h02, 3'd1, 1'b1, 1'b0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 37; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].gnt,
                          vecs[i].idx, vecs[i].valid, vecs[i].to);
        end

        // Reset in the middle of a grant, then arbitration restarts at 0
        applyStimulus(1'b0, 8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h02, 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        // Sole requester timed out is regranted right after the idle cycle
        applyStimulus(1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h01, 8'h00, 3'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        testsRun++;
        if (scoreboard.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard drain: got %0d entries, expected 0", scoreboard.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
